mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one external memory port between the I-cache and D-cache miss/writeback
//   engines, which sit below the pipeline's ICACHE_*/DCACHE_* interfaces.
//   Grants one requester at a time and drives the registered memory command for it.
//   Holds the grant until the memory handshake completes.
//   Selects the next owner by fixed D-priority or by round-robin.
// PARAMETERS
//   ADDR_W      28   memory block address width (word address >> 2)
//   DATA_W      128  memory block data width
//   D_PRIORITY  1    1: D-cache always wins ties; 0: round-robin on ties
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   i_read     in   1       I-cache requests a block read
//   i_write    in   1       I-cache requests a block write (unused by I-cache; legal)
//   i_addr     in   ADDR_W  I-cache block address
//   i_wdata    in   DATA_W  I-cache write block
//   i_rdata    out  DATA_W  read block to I-cache; valid only when i_ready=1
//   i_ready    out  1       I-cache transaction complete (1-cycle pulse)
//   d_read     in   1       D-cache requests a block read
//   d_write    in   1       D-cache requests a block write
//   d_addr     in   ADDR_W  D-cache block address
//   d_wdata    in   DATA_W  D-cache write block
//   d_rdata    out  DATA_W  read block to D-cache; valid only when d_ready=1
//   d_ready    out  1       D-cache transaction complete (1-cycle pulse)
//   mem_read   out  1       registered read command to memory
//   mem_write  out  1       registered write command to memory
//   mem_addr   out  ADDR_W  registered memory address
//   mem_wdata  out  DATA_W  registered memory write data
//   mem_rdata  in   DATA_W  memory read data; valid with mem_ready
//   mem_ready  in   1       memory completes the current command
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, last_grant=I.
//   mem_read/mem_write/mem_addr/mem_wdata=0; i_ready=d_ready=0.
// - Request handling:
//   - A requester is pending when its read|write is high.
//   - Requesters hold request/addr/wdata stable until their ready pulse.
//   - Requesters drop the request on the edge after ready.
// - FSM states: IDLE, BUSY_I, BUSY_D.
//   - IDLE, no pending requester: stay; mem_* commands stay 0.
//   - IDLE, one pending requester: at the next edge, go to BUSY_x.
//     Latch addr, wdata and op into mem_* regs. mem_read/mem_write assert from that edge.
//   - IDLE, both pending:
//     - D_PRIORITY=1: grant D.
//     - D_PRIORITY=0: grant the requester != last_grant.
//   - BUSY_x, mem_ready=0: hold all mem_* regs unchanged. Requester inputs are ignored.
//   - BUSY_x, mem_ready=1:
//     - x_ready=1 combinationally in the same cycle. The other ready stays 0.
//     - At the edge: clear mem_read/mem_write, set last_grant=x, return to IDLE.
// - Read data: i_rdata=d_rdata=mem_rdata pass-through (no gating, no register).
//   Consumers qualify it with their ready.
// - Latency:
//   - Request seen in IDLE at cycle 0 -> mem command high in cycle 1.
//   - mem_ready in cycle N -> x_ready in cycle N.
//   - Earliest next command in cycle N+2. IDLE is at N+1 and samples fresh requests.
// - Corner cases:
//   - read and write both high from one requester: write wins; sim assertion fires.
//   - mem_ready while in IDLE: ignored; no ready pulses.
//   - Request change during BUSY: ignored; the latched command is not altered.
//   - Reset mid-transaction: command dropped immediately; no ready pulse; FSM in IDLE.
//   - Never assert mem_read and mem_write together.
//   - Never assert i_ready and d_ready together.
// TESTING
// 1. Single I read:
//    - Stimulus: i_read, i_addr=28'h0000040, memory mem_ready after 3 cycles, mem_rdata=128'hA5..A5.
//    - Required: mem_read in cycles 1-4, mem_addr=0x40.
//    - Required: i_ready pulse in cycle 4 with i_rdata=A5..A5; d_ready stays 0.
// 2. D write:
//    - Stimulus: d_write, d_addr=0x123, d_wdata=128'h1.
//    - Required: mem_write=1, mem_addr=0x123, mem_wdata=1 until mem_ready.
//    - Required: one d_ready pulse; mem_write=0 the next cycle.
// 3. Tie, D_PRIORITY=1: i_read and d_read both high in cycle 0.
//    - D is served first.
//    - I is granted in the cycle after D's ready (IDLE), command issued the cycle after.
// 4. Tie, D_PRIORITY=0: both requesters continuously request for 4 transactions.
//    - Grant order is D,I,D,I (last_grant=I after reset).
// 5. Async reset during BUSY_D, with mem_ready not yet seen:
//    - Outputs go to 0 without waiting for clk; state=IDLE.
//    - After rst deasserts with d_read still high, D is re-granted.
// 6. mem_ready pulsed in IDLE with no requests: no i_ready/d_ready; mem_* stay 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the I-cache and D-cache engines.
// Registered command per grant; the grant is held until mem_ready completes it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t            state, state_n;
  logic              last_d, last_d_n;
  logic              mem_read_n, mem_write_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              i_pend, d_pend, grant_i, grant_d;
  assign i_pend  = i_read | i_write;
  assign d_pend  = d_read | d_write;
  // On a tie D wins under fixed priority, otherwise whoever was not served last
  assign grant_d = d_pend & (!i_pend | D_PRIORITY | !last_d);
  assign grant_i = i_pend & !grant_d;
  assign i_ready = (state == BUSY_I) & mem_ready;
  assign d_ready = (state == BUSY_D) & mem_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  always_comb begin
    state_n     = state;
    last_d_n    = last_d;
    mem_read_n  = mem_read;
    mem_write_n = mem_write;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if (state == IDLE && (grant_d || grant_i)) begin
      state_n     = grant_d ? BUSY_D : BUSY_I;
      mem_write_n = grant_d ? d_write : i_write;
      mem_read_n  = grant_d ? d_read & !d_write : i_read & !i_write;
      mem_addr_n  = grant_d ? d_addr : i_addr;
      mem_wdata_n = grant_d ? d_wdata : i_wdata;
    end else if (state != IDLE && mem_ready) begin
      state_n     = IDLE;
      last_d_n    = state == BUSY_D;
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      last_d    <= last_d_n;
      mem_read  <= mem_read_n;
      mem_write <= mem_write_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end
  a_i_rw: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
  a_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
  a_mem_rw: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
endmodule
